// File: rtl/video_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_cap_pkg
// Purpose  : Shared types and constants for the video field capture block.
//            Holds the capture FSM state encoding, capture mode codes and
//            default frame geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package video_cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_NEXT    = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_t;

  localparam logic [1:0] MODE_ODD  = 2'b00;
  localparam logic [1:0] MODE_EVEN = 2'b01;
  localparam logic [1:0] MODE_ILV  = 2'b10;

  localparam int DEF_H_PIX   = 720;
  localparam int DEF_V_LINES = 288;

  // Code 11 is an alias of odd-only capture.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_ODD : m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/field_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : field_edge_det
// Purpose  : Brings the asynchronous decoder odd/even level into the pixel
//            clock domain and emits one-cycle field start pulses.
// Ports    : clk_in        pixel clock
//            rst_in        asynchronous active-high reset
//            oe_in         async odd/even level (1 = odd field)
//            odd_start_o   1-cycle pulse on rising edge of oe_in
//            even_start_o  1-cycle pulse on falling edge of oe_in
// Revision : 1.0 - initial release
// ============================================================================
module field_edge_det (
  input  logic clk_in,
  input  logic rst_in,
  input  logic oe_in,
  output logic odd_start_o,
  output logic even_start_o
);

  logic [1:0] sync_q;
  logic       oe_prev_q;
  logic       odd_q;
  logic       even_q;

  // Two synchronizer flops, one history flop, and registered pulses:
  // a pulse appears three clocks after oe_in toggles.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q    <= 2'b00;
      oe_prev_q <= 1'b0;
      odd_q     <= 1'b0;
      even_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], oe_in};
      oe_prev_q <= sync_q[1];
      odd_q     <= sync_q[1] & ~oe_prev_q;
      even_q    <= ~sync_q[1] & oe_prev_q;
    end
  end

  assign odd_start_o  = odd_q;
  assign even_start_o = even_q;

endmodule
`default_nettype wire

// File: rtl/field_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : field_capture_ctrl
// Purpose  : Waits for the selected video field, then streams its pixels to
//            the frame buffer with progressive or interleaved addressing.
// Ports    : clk_in/rst_in           pixel clock, async active-high reset
//            oe_in                   decoder odd/even level (async)
//            href_in/pix_valid_in    line-active and pixel qualifier
//            pix_in                  16-bit pixel data
//            start_in/abort_in       arm pulse / force-idle level
//            cont_in                 re-arm automatically after DONE
//            mode_in                 00 odd, 01 even, 10 interleaved, 11 odd
//            wr_valid/wr_addr/wr_data/wr_ready  frame-buffer write port
//            busy/done/field_id      status
//            ovf_err/short_err       sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module field_capture_ctrl
  import video_cap_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_LINES = DEF_V_LINES
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              oe_in,
  input  logic              href_in,
  input  logic              pix_valid_in,
  input  logic [15:0]       pix_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              cont_in,
  input  logic [1:0]        mode_in,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              field_id,
  output logic              ovf_err,
  output logic              short_err
);

  localparam int PW = $clog2(H_PIX + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam logic [ADDR_W-1:0] STEP_PROG = ADDR_W'(H_PIX);
  localparam logic [ADDR_W-1:0] STEP_ILV  = ADDR_W'(2 * H_PIX);

  logic odd_start;
  logic even_start;

  field_edge_det u_edge (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .oe_in        (oe_in),
    .odd_start_o  (odd_start),
    .even_start_o (even_start)
  );

  cap_state_t        state_q;
  logic [1:0]        mode_q;
  logic              field_q;
  logic              href_q;
  logic [PW-1:0]     pix_cnt_q;
  logic [PW-1:0]     pix_cnt_d;
  logic [PW-1:0]     pix_idx;
  logic [LW-1:0]     line_cnt_q;
  logic [ADDR_W-1:0] line_base_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
  logic              done_q;
  logic              ovf_q;
  logic              short_q;

  logic href_rise, href_fall, pixel, in_cap, wr_hit, lines_full, field_edge;

  always_comb begin
    href_rise  = href_in & ~href_q;
    href_fall  = ~href_in & href_q;
    pixel      = href_in & pix_valid_in;
    // A pixel on the first cycle of a line is index 0 even though the stored
    // count still holds the previous line's length.
    pix_idx    = href_rise ? '0 : pix_cnt_q;
    // Count saturates at H_PIX so overlong lines cannot wrap back into range.
    pix_cnt_d  = (pixel && (pix_idx < PW'(H_PIX))) ? pix_idx + PW'(1) : pix_idx;
    in_cap     = (state_q == ST_CAPTURE);
    wr_hit     = in_cap && pixel && (pix_idx < PW'(H_PIX)) && (line_cnt_q < LW'(V_LINES));
    lines_full = in_cap && href_fall && (line_cnt_q == LW'(V_LINES - 1));
    field_edge = odd_start | even_start;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ODD;
      field_q     <= 1'b0;
      href_q      <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      line_base_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      href_q    <= href_in;
      pix_cnt_q <= pix_cnt_d;

      if (in_cap && href_fall) begin
        line_cnt_q  <= line_cnt_q + LW'(1);
        line_base_q <= line_base_q + ((mode_q == MODE_ILV) ? STEP_ILV : STEP_PROG);
      end

      // Single-entry write register: a new pixel replaces a pending one.
      if (wr_hit) begin
        wr_valid_q <= 1'b1;
        wr_addr_q  <= line_base_q + ADDR_W'(pix_idx);
        wr_data_q  <= pix_in;
        if (wr_valid_q && !wr_ready) ovf_q <= 1'b1;
      end else if (wr_ready) begin
        wr_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            state_q <= ST_ARM;
            mode_q  <= norm_mode(mode_in);
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
          end
        end
        ST_ARM: begin
          if ((mode_q == MODE_EVEN) ? even_start : odd_start) begin
            state_q     <= ST_CAPTURE;
            field_q     <= (mode_q != MODE_EVEN);
            line_cnt_q  <= '0;
            line_base_q <= '0;
          end
        end
        ST_CAPTURE: begin
          if (lines_full || field_edge) begin
            if (!lines_full) short_q <= 1'b1;
            if ((mode_q == MODE_ILV) && field_q) begin
              // The edge that closes the odd field may itself be the even
              // field start; in that case capture continues without a gap.
              if (even_start) begin
                field_q     <= 1'b0;
                line_cnt_q  <= '0;
                line_base_q <= STEP_PROG;
              end else begin
                state_q <= ST_NEXT;
              end
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_NEXT: begin
          if (even_start) begin
            state_q     <= ST_CAPTURE;
            field_q     <= 1'b0;
            line_cnt_q  <= '0;
            line_base_q <= STEP_PROG;
          end
        end
        ST_DONE: begin
          if (start_in) begin
            state_q <= ST_ARM;
            mode_q  <= norm_mode(mode_in);
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
          end else if (cont_in) begin
            state_q <= ST_ARM;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (abort_in) begin
        state_q    <= ST_IDLE;
        wr_valid_q <= 1'b0;
        done_q     <= 1'b0;
      end
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = done_q;
  assign field_id  = field_q;
  assign ovf_err   = ovf_q;
  assign short_err = short_q;

endmodule
`default_nettype wire

// File: tb/tb_field_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_field_capture_ctrl
// Purpose  : Directed self-checking bench for field_capture_ctrl with a short
//            field (V_LINES = 4) and full-width lines (H_PIX = 720).
// Revision : 1.0 - initial release
// ============================================================================
module tb_field_capture_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, oe_in, href_in, pix_valid_in;
  logic [15:0] pix_in;
  logic        start_in, abort_in, cont_in;
  logic [1:0]  mode_in;
  logic        wr_valid, wr_ready, busy, done, field_id, ovf_err, short_err;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  logic [15:0] pdata = 16'h1000;
  logic [18:0] log_addr[$];
  logic [15:0] log_data[$];
  int          exp_q[$];

  always #5 clk_in = ~clk_in;

  field_capture_ctrl #(.ADDR_W(19), .H_PIX(720), .V_LINES(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .oe_in        (oe_in),
    .href_in      (href_in),
    .pix_valid_in (pix_valid_in),
    .pix_in       (pix_in),
    .start_in     (start_in),
    .abort_in     (abort_in),
    .cont_in      (cont_in),
    .mode_in      (mode_in),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .busy         (busy),
    .done         (done),
    .field_id     (field_id),
    .ovf_err      (ovf_err),
    .short_err    (short_err)
  );

  // Record every completed write transfer and every done pulse.
  always @(negedge clk_in) begin
    if (wr_valid && wr_ready) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic set_oe(input logic v);
    oe_in = v;
    cyc(6);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode_in  = m;
    start_in = 1'b1;
    cyc(1);
    start_in = 1'b0;
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      href_in = 1'b1; pix_valid_in = 1'b1; pix_in = pdata; pdata++;
      cyc(1);
    end
    href_in = 1'b0; pix_valid_in = 1'b0;
    cyc(4);
  endtask

  task automatic exp_lines(input int base, input int stride, input int nl, input int np);
    for (int l = 0; l < nl; l++)
      for (int p = 0; p < np; p++) exp_q.push_back(base + l * stride + p);
  endtask

  task automatic check_log(input string tag);
    int bad = 0;
    chk({tag, "_count"}, log_addr.size(), exp_q.size());
    for (int i = 0; i < log_addr.size() && i < exp_q.size(); i++)
      if (log_addr[i] !== 19'(exp_q[i])) bad++;
    chk({tag, "_addr_mismatches"}, bad, 0);
  endtask

  initial begin
    rst_in = 1'b1; oe_in = 1'b0; href_in = 1'b0; pix_valid_in = 1'b0; pix_in = '0;
    start_in = 1'b0; abort_in = 1'b0; cont_in = 1'b0; mode_in = 2'b00; wr_ready = 1'b1;
    cyc(3);
    rst_in = 1'b0;
    cyc(2);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_field_id", field_id, 0);
    chk("rst_errs", {ovf_err, short_err}, 0);

    // Mode 00: one odd field of 4 x 720 pixels, contiguous addresses.
    clear_log();
    pdata = 16'h1000;
    pulse_start(2'b00);
    chk("m00_busy_armed", busy, 1);
    set_oe(1'b1);
    for (int l = 0; l < 4; l++) send_line(720);
    exp_lines(0, 720, 4, 720);
    check_log("m00");
    begin
      int bad = 0;
      for (int i = 0; i < log_data.size(); i++)
        if (log_data[i] !== 16'(32'h1000 + i)) bad++;
      chk("m00_data_mismatches", bad, 0);
    end
    chk("m00_field_id", field_id, 1);
    chk("m00_done_pulses", done_cnt, 1);
    chk("m00_busy_after", busy, 0);
    chk("m00_short", short_err, 0);

    // Mode 10: odd lines at 0,1440,.. then even lines at 720,2160,..
    set_oe(1'b0);
    clear_log();
    pulse_start(2'b10);
    set_oe(1'b1);
    for (int l = 0; l < 4; l++) send_line(720);
    chk("ilv_next_busy", busy, 1);
    chk("ilv_next_no_done", done_cnt, 0);
    set_oe(1'b0);
    chk("ilv_even_field_id", field_id, 0);
    for (int l = 0; l < 4; l++) send_line(720);
    exp_lines(0, 1440, 4, 720);
    exp_lines(720, 1440, 4, 720);
    check_log("ilv");
    chk("ilv_done_pulses", done_cnt, 1);
    chk("ilv_short", short_err, 0);

    // Mode 01: odd field in progress at start is skipped; overlong line clipped.
    set_oe(1'b1);
    clear_log();
    pulse_start(2'b01);
    send_line(8);
    chk("m01_no_write_in_odd", log_addr.size(), 0);
    set_oe(1'b0);
    send_line(722);
    for (int l = 0; l < 3; l++) send_line(8);
    exp_lines(0, 720, 1, 720);
    exp_lines(720, 720, 3, 8);
    check_log("m01");
    chk("m01_field_id", field_id, 0);
    chk("m01_done_pulses", done_cnt, 1);

    // Mode 00 short field: oe falls after 2 lines.
    clear_log();
    pulse_start(2'b00);
    set_oe(1'b1);
    send_line(8);
    send_line(8);
    set_oe(1'b0);
    exp_lines(0, 720, 2, 8);
    check_log("short00");
    chk("short00_flag", short_err, 1);
    chk("short00_done", done_cnt, 1);
    chk("short00_busy", busy, 0);

    // Mode 10 short odd field: even_start starts even capture immediately.
    clear_log();
    pulse_start(2'b10);
    chk("short10_flag_cleared", short_err, 0);
    set_oe(1'b1);
    send_line(8);
    send_line(8);
    set_oe(1'b0);
    chk("short10_flag", short_err, 1);
    chk("short10_even_busy", busy, 1);
    chk("short10_field_id", field_id, 0);
    for (int l = 0; l < 4; l++) send_line(8);
    exp_lines(0, 1440, 2, 8);
    exp_lines(720, 1440, 4, 8);
    check_log("short10");
    chk("short10_done", done_cnt, 1);

    // Overflow: wr_ready low across pixels; last pixel overwrites pending write.
    clear_log();
    pulse_start(2'b00);
    set_oe(1'b1);
    wr_ready = 1'b0;
    send_line(3);
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_pending_valid", wr_valid, 1);
    chk("ovf_pending_addr", wr_addr, 2);
    wr_ready = 1'b1;
    for (int l = 0; l < 3; l++) send_line(4);
    chk("ovf_done", done_cnt, 1);
    chk("ovf_sticky_after_done", ovf_err, 1);

    // Abort mid-line after automatic re-arm: flags kept, no done.
    clear_log();
    cont_in = 1'b1;
    cyc(1);
    cont_in = 1'b0;
    chk("cont_rearm_busy", busy, 1);
    chk("cont_keeps_ovf", ovf_err, 1);
    set_oe(1'b0);
    set_oe(1'b1);
    href_in = 1'b1; pix_valid_in = 1'b1;
    cyc(3);
    chk("abort_pre_valid", wr_valid, 1);
    abort_in = 1'b1;
    cyc(1);
    chk("abort_wr_valid", wr_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_keeps_ovf", ovf_err, 1);
    abort_in = 1'b0; href_in = 1'b0; pix_valid_in = 1'b0;
    cyc(4);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle_no_write", wr_valid, 0);

    // Reset mid-capture clears everything including error flags.
    clear_log();
    pulse_start(2'b00);
    chk("start_clears_ovf", ovf_err, 0);
    set_oe(1'b0);
    set_oe(1'b1);
    wr_ready = 1'b0;
    href_in = 1'b1; pix_valid_in = 1'b1;
    cyc(3);
    chk("rstmid_ovf_set", ovf_err, 1);
    rst_in = 1'b1;
    #1;
    chk("rstmid_wr_valid", wr_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_errs", {ovf_err, short_err}, 0);
    chk("rstmid_field_id", field_id, 0);
    cyc(2);
    rst_in = 1'b0; href_in = 1'b0; pix_valid_in = 1'b0; wr_ready = 1'b1;
    cyc(4);
    chk("rstmid_no_done", done_cnt, 0);
    chk("rstmid_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
